// File: rtl/add_norm_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : add_norm_pipe                                                    |
// | Brief   : 2-stage valid/ready normaliser, signed sum -> sign/mantissa/exp  |
// | Revision: 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------------+
module add_norm_pipe #(
  parameter int SUM_W = 20,
  parameter int EXP_W = 6,
  parameter int MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] signed_sum_in,
  input  logic [EXP_W-1:0] exp_max_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [MAN_W-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             zero_out,
  output logic             ovf_out
);

  localparam int LZ_W = (SUM_W > 2) ? $clog2(SUM_W) : 1;
  localparam int E_W  = EXP_W + 1;

  logic adv1;
  logic adv2;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [SUM_W-1:0] s1_mag_q,   s1_mag_d;
  logic [LZ_W-1:0]  s1_lz_q,    s1_lz_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic             s1_zero_q,  s1_zero_d;

  logic             s2_valid_q, s2_valid_d;
  logic             sign_q,     sign_d;
  logic [MAN_W-1:0] mant_q,     mant_d;
  logic [EXP_W-1:0] exp_q,      exp_d;
  logic             zero_q,     zero_d;
  logic             ovf_q,      ovf_d;

  logic [SUM_W-1:0] in_mag;
  logic [LZ_W-1:0]  in_lz;
  logic [SUM_W-1:0] norm;
  logic [E_W-1:0]   e_sum;

  // Back-pressure ripples from the output side only; in_valid never gates ready.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    in_mag = signed_sum_in[SUM_W-1] ? (~signed_sum_in + 1'b1) : signed_sum_in;
    in_lz  = LZ_W'(SUM_W - 1);
    for (int i = 0; i < SUM_W; i++) begin
      if (in_mag[i]) in_lz = LZ_W'(SUM_W - 1 - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_lz_d    = s1_lz_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = signed_sum_in[SUM_W-1];
        s1_mag_d  = in_mag;
        s1_lz_d   = in_lz;
        s1_exp_d  = exp_max_in;
        s1_zero_d = (in_mag == '0);
      end
    end
  end

  always_comb begin
    norm  = s1_mag_q << s1_lz_q;
    e_sum = E_W'(s1_exp_q) + E_W'(SUM_W - 1) - E_W'(s1_lz_q);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    sign_d     = sign_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_zero_q) begin
          sign_d = 1'b0;
          mant_d = '0;
          exp_d  = '0;
          zero_d = 1'b1;
          ovf_d  = 1'b0;
        end else if (e_sum[EXP_W]) begin
          // Exponent out of range: saturate magnitude and exponent, keep sign.
          sign_d = s1_sign_q;
          mant_d = '1;
          exp_d  = '1;
          zero_d = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          sign_d = s1_sign_q;
          mant_d = norm[SUM_W-1 -: MAN_W];
          exp_d  = e_sum[EXP_W-1:0];
          zero_d = 1'b0;
          ovf_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_lz_q    <= '0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_lz_q    <= s1_lz_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      sign_q     <= sign_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_out  = sign_q;
  assign mant_out  = mant_q;
  assign exp_out   = exp_q;
  assign zero_out  = zero_q;
  assign ovf_out   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add_norm_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_add_norm_pipe                                                 |
// | Brief   : randomised + directed bench for add_norm_pipe with a value model |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_add_norm_pipe;

  localparam int SUM_W = 20;
  localparam int EXP_W = 6;
  localparam int MAN_W = 10;
  localparam int RES_W = 1 + MAN_W + EXP_W + 2;

  typedef logic [RES_W-1:0] res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] signed_sum_in;
  logic [EXP_W-1:0] exp_max_in;
  logic             out_valid;
  logic             out_ready;
  logic             sign_out;
  logic [MAN_W-1:0] mant_out;
  logic [EXP_W-1:0] exp_out;
  logic             zero_out;
  logic             ovf_out;

  always #5 clk = ~clk;

  add_norm_pipe #(.SUM_W(SUM_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .signed_sum_in(signed_sum_in), .exp_max_in(exp_max_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .mant_out(mant_out), .exp_out(exp_out),
    .zero_out(zero_out), .ovf_out(ovf_out)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb_q[$];
  logic prev_stall;
  res_t prev_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic res_t pack(input logic sg, input logic [MAN_W-1:0] mt,
                                input logic [EXP_W-1:0] ex, input logic z, input logic o);
    return {sg, mt, ex, z, o};
  endfunction

  // Value-level model: find the MSB of |sum| and take the top MAN_W bits from there.
  function automatic res_t model(input logic [SUM_W-1:0] s, input logic [EXP_W-1:0] e_in);
    longint v, m, e, mt;
    int     p;
    logic   sg;
    v  = longint'($signed(s));
    sg = (v < 0);
    m  = sg ? -v : v;
    if (m == 0) return pack(1'b0, '0, '0, 1'b1, 1'b0);
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = longint'(e_in) + p;
    if (p >= MAN_W - 1) mt = m >> (p - (MAN_W - 1));
    else                mt = m << ((MAN_W - 1) - p);
    if (e > (1 << EXP_W) - 1) return pack(sg, '1, '1, 1'b0, 1'b1);
    return pack(sg, mt[MAN_W-1:0], e[EXP_W-1:0], 1'b0, 1'b0);
  endfunction

  function automatic res_t dut_res();
    return {sign_out, mant_out, exp_out, zero_out, ovf_out};
  endfunction

  // One clock: drive after the rising edge, observe handshakes at the falling edge.
  task automatic cycle(input logic v, input logic [SUM_W-1:0] s,
                       input logic [EXP_W-1:0] e, input logic ordy);
    @(posedge clk);
    #1;
    in_valid      = v;
    signed_sum_in = s;
    exp_max_in    = e;
    out_ready     = ordy;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", dut_res(), prev_res);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_out", out_valid, 0);
      else                  check("out_data", dut_res(), sb_q.pop_front());
    end
    if (in_valid && in_ready) sb_q.push_back(model(s, e));
    prev_stall = out_valid && !out_ready;
    prev_res   = dut_res();
  endtask

  task automatic single(input string tag, input logic [SUM_W-1:0] s,
                        input logic [EXP_W-1:0] e, input res_t expv);
    cycle(1'b1, s, e, 1'b1);
    check({tag, "_acc"}, in_ready, 1);
    cycle(1'b0, '0, '0, 1'b1);
    check({tag, "_lat1"}, out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1);
    check({tag, "_lat2"}, out_valid, 1);
    check(tag, dut_res(), expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      rnd;
    logic [SUM_W-1:0] s;
    rst           = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    signed_sum_in = '0;
    exp_max_in    = '0;
    prev_stall    = 1'b0;
    prev_res      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", dut_res(), 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    single("d_one",    20'h00001, 6'd3,  pack(1'b0, 10'h200, 6'd3,  1'b0, 1'b0));
    single("d_neg1",   20'hFFFFF, 6'd5,  pack(1'b1, 10'h200, 6'd5,  1'b0, 1'b0));
    single("d_minneg", 20'h80000, 6'd10, pack(1'b1, 10'h200, 6'd29, 1'b0, 1'b0));
    single("d_trunc",  20'h7FFFF, 6'd0,  pack(1'b0, 10'h3FF, 6'd18, 1'b0, 1'b0));
    single("d_ovf",    20'h40000, 6'd50, pack(1'b0, 10'h3FF, 6'h3F, 1'b0, 1'b1));
    single("d_zero",   20'h00000, 6'd17, pack(1'b0, 10'h000, 6'd0,  1'b1, 1'b0));
    cycle(1'b0, '0, '0, 1'b1);

    // Back-pressure: A, B fill both stages, C waits, then drains in order.
    cycle(1'b1, 20'h00123, 6'd4, 1'b0);  check("bp_acc_a", in_ready, 1);
    cycle(1'b1, 20'hF0F00, 6'd9, 1'b0);  check("bp_acc_b", in_ready, 1);
    cycle(1'b1, 20'h3C001, 6'd1, 1'b0);  check("bp_full_c", in_ready, 0);
    check("bp_valid_a", out_valid, 1);
    check("bp_data_a", dut_res(), model(20'h00123, 6'd4));
    cycle(1'b1, 20'h3C001, 6'd1, 1'b0);  check("bp_full_c2", in_ready, 0);
    cycle(1'b1, 20'h3C001, 6'd1, 1'b1);  check("bp_simul_c", in_ready, 1);
    cycle(1'b1, 20'h80001, 6'd40, 1'b1); check("bp_acc_d", in_ready, 1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    check("bp_drained", sb_q.size(), 0);

    // Reset with two entries in flight.
    cycle(1'b1, 20'h0ABCD, 6'd7, 1'b0);
    cycle(1'b1, 20'hC0000, 6'd2, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", dut_res(), 0);
    sb_q.delete();
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    single("post_rst", 20'h00300, 6'd20, pack(1'b0, 10'h300, 6'd29, 1'b0, 1'b0));
    repeat (4) cycle(1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      case ($urandom_range(0, 7))
        0:       s = '0;
        1:       s = 20'h80000;
        2:       s = 20'h7FFFF;
        default: s = rnd[SUM_W-1:0] >> $urandom_range(0, SUM_W - 1);
      endcase
      if ($urandom_range(0, 1) == 1) s = -s;
      rnd = $urandom;
      cycle($urandom_range(0, 3) != 0, s, rnd[EXP_W-1:0], $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b1);
    check("final_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
